// File: rtl/dpa_pkg.sv
// rtl/dpa_pkg.sv - shared types and helpers for the crossbar VOQ/arbiter slice
package dpa_pkg;

    localparam int N_PORTS = 4;
    localparam int FLIT_W  = 32;

    typedef logic [$clog2(N_PORTS)-1:0] port_idx_t;
    typedef logic [FLIT_W-1:0]          flit_t;

    // Index of the highest set bit; only meaningful for a one-hot input.
    function automatic int unsigned onehot_to_idx(input logic [31:0] onehot);
        int unsigned idx;
        idx = 0;
        for (int i = 0; i < 32; i++) begin
            if (onehot[i]) idx = i;
        end
        return idx;
    endfunction

endpackage

// File: rtl/dpa_voq_fifo.sv
// rtl/dpa_voq_fifo.sv - single circular FIFO backing one virtual output queue
module dpa_voq_fifo
    import dpa_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  logic                       pop,
    input  logic [DATA_W-1:0]          din,
    output logic [DATA_W-1:0]          dout,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;

    // DEPTH is a power of two, so pointer wrap is plain binary overflow.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= din;
    end

    assign dout  = mem[rd_ptr];
    assign empty = (count == '0);
    assign full  = (count == CNT_W'(DEPTH));

endmodule

// File: rtl/dpa_voq_buffer.sv
// rtl/dpa_voq_buffer.sv - per-input VOQ buffer feeding one row of the arbiter request matrix
module dpa_voq_buffer
    import dpa_pkg::*;
#(
    parameter int N      = N_PORTS,
    parameter int DATA_W = 32,
    parameter int DEPTH  = 8
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           in_valid,
    output logic                           in_ready,
    input  logic [$clog2(N)-1:0]           in_dest,
    input  logic [DATA_W-1:0]              in_data,
    output logic [N-1:0]                   request,
    input  logic [N-1:0]                   grant,
    output logic                           out_valid,
    output logic [$clog2(N)-1:0]           out_dest,
    output logic [DATA_W-1:0]              out_data,
    output logic [N*$clog2(DEPTH+1)-1:0]   occupancy,
    output logic                           err_grant
);

    localparam int IDX_W = $clog2(N);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [N-1:0]       push;
    logic [N-1:0]       pop;
    logic [N-1:0]       full;
    logic [N-1:0]       empty;
    logic [DATA_W-1:0]  head  [N];
    logic [CNT_W-1:0]   count [N];
    logic               grant_ok;
    logic [IDX_W-1:0]   grant_idx;

    // Full is judged on the registered count, so a same-cycle pop never opens in_ready.
    assign in_ready  = ~full[in_dest];
    assign grant_ok  = $onehot(grant) && ((grant & request) != '0);
    assign grant_idx = IDX_W'(onehot_to_idx(32'(grant)));

    for (genvar k = 0; k < N; k++) begin : gen_voq
        assign push[k]    = in_valid & in_ready & (in_dest == IDX_W'(k));
        assign pop[k]     = grant_ok & grant[k];
        assign request[k] = ~empty[k];
        assign occupancy[k*CNT_W +: CNT_W] = count[k];

        dpa_voq_fifo #(
            .DATA_W (DATA_W),
            .DEPTH  (DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .push  (push[k]),
            .pop   (pop[k]),
            .din   (in_data),
            .dout  (head[k]),
            .count (count[k]),
            .empty (empty[k]),
            .full  (full[k])
        );
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_dest  <= '0;
            out_data  <= '0;
            err_grant <= 1'b0;
        end else begin
            out_valid <= grant_ok;
            if (grant_ok) begin
                out_dest <= grant_idx;
                out_data <= head[grant_idx];
            end
            if ((grant != '0) && !grant_ok) err_grant <= 1'b1;
        end
    end

    // Multi-hot is an arbiter bug; flag it loudly but keep simulating.
    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (grant == '0 || $onehot(grant))
                else $warning("dpa_voq_buffer: multi-hot grant %b", grant);
        end
    end

endmodule

// File: tb/tb_dpa_voq_buffer.sv
// tb/tb_dpa_voq_buffer.sv - scoreboard bench for dpa_voq_buffer
module tb_dpa_voq_buffer;

    localparam int N      = 4;
    localparam int DATA_W = 32;
    localparam int DEPTH  = 8;
    localparam int IDX_W  = 2;
    localparam int CNT_W  = 4;

    logic                  clk = 1'b0;
    logic                  rst;
    logic                  in_valid;
    logic                  in_ready;
    logic [IDX_W-1:0]      in_dest;
    logic [DATA_W-1:0]     in_data;
    logic [N-1:0]          request;
    logic [N-1:0]          grant;
    logic                  out_valid;
    logic [IDX_W-1:0]      out_dest;
    logic [DATA_W-1:0]     out_data;
    logic [N*CNT_W-1:0]    occupancy;
    logic                  err_grant;

    int n_cmp = 0;
    int n_bad = 0;

    logic [DATA_W-1:0]        mq [N][$];
    logic [IDX_W+DATA_W-1:0]  exp_q [$];
    logic                     m_err;
    logic [IDX_W-1:0]         m_dest;
    logic [DATA_W-1:0]        m_data;

    dpa_voq_buffer #(.N(N), .DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_dest   (in_dest),
        .in_data   (in_data),
        .request   (request),
        .grant     (grant),
        .out_valid (out_valid),
        .out_dest  (out_dest),
        .out_data  (out_data),
        .occupancy (occupancy),
        .err_grant (err_grant)
    );

    always #5 clk = ~clk;

    // Apply one edge: update the model from the current inputs, then compare outputs.
    task automatic tick();
        bit                      exp_v;
        int                      sz [N];
        int                      gi;
        logic [IDX_W+DATA_W-1:0] e;
        exp_v = 1'b0;
        gi = 0;
        if (rst) begin
            for (int k = 0; k < N; k++) mq[k].delete();
            exp_q.delete();
            m_err  = 1'b0;
            m_dest = '0;
            m_data = '0;
        end else begin
            for (int k = 0; k < N; k++) begin
                sz[k] = mq[k].size();
                if (grant[k]) gi = k;
            end
            if ($onehot(grant) && sz[gi] > 0) begin
                exp_q.push_back({IDX_W'(gi), mq[gi].pop_front()});
                exp_v = 1'b1;
            end else if (grant != '0) begin
                m_err = 1'b1;
            end
            if (in_valid && sz[in_dest] < DEPTH) mq[in_dest].push_back(in_data);
        end
        @(posedge clk);
        #1;
        n_cmp++;
        if (out_valid !== exp_v) begin
            n_bad++;
            $display("FAIL out_valid: got %b expected %b", out_valid, exp_v);
        end
        if (exp_v && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            m_dest = e[IDX_W+DATA_W-1:DATA_W];
            m_data = e[DATA_W-1:0];
        end
        n_cmp++;
        if (out_dest !== m_dest || out_data !== m_data) begin
            n_bad++;
            $display("FAIL out_flit: got dest %0d data %h expected dest %0d data %h",
                     out_dest, out_data, m_dest, m_data);
        end
    endtask

    task automatic push_flit(input int d, input logic [DATA_W-1:0] data);
        in_valid = 1'b1;
        in_dest  = IDX_W'(d);
        in_data  = data;
        tick();
        in_valid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_dest = '0; in_data = '0; grant = '0;
        tick();
        tick();
        rst = 1'b0;
        tick();
        n_cmp++;
        if (request !== 4'b0000 || err_grant !== 1'b0 || occupancy !== '0) begin
            n_bad++;
            $display("FAIL reset_state: got req %b err %b occ %h expected 0 0 0",
                     request, err_grant, occupancy);
        end
        for (int d = 0; d < N; d++) begin
            in_dest = IDX_W'(d);
            #1;
            n_cmp++;
            if (in_ready !== 1'b1) begin
                n_bad++;
                $display("FAIL reset_in_ready: dest %0d got %b expected 1", d, in_ready);
            end
        end
    endtask

    task automatic test_basic();
        push_flit(2, 32'hA0);
        push_flit(2, 32'hA1);
        push_flit(0, 32'hB0);
        n_cmp++;
        if (request !== 4'b0101) begin
            n_bad++;
            $display("FAIL basic_request: got %b expected 0101", request);
        end
        grant = 4'b0100;
        tick();
        n_cmp++;
        if (out_data !== 32'hA0 || out_dest !== 2'd2) begin
            n_bad++;
            $display("FAIL basic_first: got %0d/%h expected 2/a0", out_dest, out_data);
        end
        tick();
        n_cmp++;
        if (out_data !== 32'hA1 || out_dest !== 2'd2) begin
            n_bad++;
            $display("FAIL basic_second: got %0d/%h expected 2/a1", out_dest, out_data);
        end
        grant = 4'b0000;
        tick();
        n_cmp++;
        if (request !== 4'b0001) begin
            n_bad++;
            $display("FAIL basic_after: got %b expected 0001", request);
        end
        grant = 4'b0001;
        tick();
        grant = 4'b0000;
    endtask

    task automatic test_full();
        for (int i = 0; i < DEPTH; i++) push_flit(3, 32'h300 + i);
        n_cmp++;
        if (occupancy[3*CNT_W +: CNT_W] !== 4'd8) begin
            n_bad++;
            $display("FAIL full_occ: got %0d expected 8", occupancy[3*CNT_W +: CNT_W]);
        end
        in_dest = 2'd3; #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_ready3: got %b expected 0", in_ready);
        end
        in_dest = 2'd1; #1;
        n_cmp++;
        if (in_ready !== 1'b1) begin
            n_bad++;
            $display("FAIL full_ready1: got %b expected 1", in_ready);
        end
        in_valid = 1'b1; in_dest = 2'd3; in_data = 32'h3FF; grant = 4'b1000;
        #1;
        n_cmp++;
        if (in_ready !== 1'b0) begin
            n_bad++;
            $display("FAIL full_pop_ready: got %b expected 0", in_ready);
        end
        tick();
        n_cmp++;
        if (in_ready !== 1'b1 || occupancy[3*CNT_W +: CNT_W] !== 4'd7) begin
            n_bad++;
            $display("FAIL full_after_pop: got ready %b occ %0d expected 1 7",
                     in_ready, occupancy[3*CNT_W +: CNT_W]);
        end
        grant = 4'b0000;
        tick();
        in_valid = 1'b0;
        n_cmp++;
        if (occupancy[3*CNT_W +: CNT_W] !== 4'd8) begin
            n_bad++;
            $display("FAIL full_refill: got %0d expected 8", occupancy[3*CNT_W +: CNT_W]);
        end
        grant = 4'b1000;
        repeat (DEPTH) tick();
        grant = 4'b0000;
        n_cmp++;
        if (request !== 4'b0000) begin
            n_bad++;
            $display("FAIL full_drained: got %b expected 0000", request);
        end
    endtask

    task automatic test_back_to_back();
        push_flit(1, 32'h1000);
        for (int i = 0; i < 20; i++) begin
            in_valid = 1'b1; in_dest = 2'd1; in_data = 32'h1001 + i; grant = 4'b0010;
            tick();
            n_cmp++;
            if (occupancy[1*CNT_W +: CNT_W] !== 4'd1) begin
                n_bad++;
                $display("FAIL b2b_count: cycle %0d got %0d expected 1",
                         i, occupancy[1*CNT_W +: CNT_W]);
            end
        end
        in_valid = 1'b0;
        tick();
        grant = 4'b0000;
        n_cmp++;
        if (request !== 4'b0000) begin
            n_bad++;
            $display("FAIL b2b_drained: got %b expected 0000", request);
        end
    endtask

    task automatic test_err_grant();
        n_cmp++;
        if (err_grant !== 1'b0) begin
            n_bad++;
            $display("FAIL err_pre: got %b expected 0", err_grant);
        end
        grant = 4'b1000;
        tick();
        grant = 4'b0000;
        n_cmp++;
        if (err_grant !== 1'b1 || occupancy !== '0) begin
            n_bad++;
            $display("FAIL err_empty: got err %b occ %h expected 1 0000", err_grant, occupancy);
        end
        push_flit(0, 32'hC0);
        push_flit(1, 32'hC1);
        grant = 4'b0011;
        tick();
        grant = 4'b0000;
        n_cmp++;
        if (err_grant !== m_err || occupancy !== 16'h0011) begin
            n_bad++;
            $display("FAIL err_multihot: got err %b occ %h expected %b 0011",
                     err_grant, occupancy, m_err);
        end
    endtask

    task automatic test_reset_mid();
        push_flit(2, 32'hD0);
        push_flit(3, 32'hD1);
        push_flit(2, 32'hD2);
        n_cmp++;
        if (occupancy !== 16'h1211) begin
            n_bad++;
            $display("FAIL mid_occ: got %h expected 1211", occupancy);
        end
        rst = 1'b1; grant = 4'b0001;
        tick();
        rst = 1'b0; grant = 4'b0000;
        n_cmp++;
        if (request !== 4'b0000 || err_grant !== 1'b0 || occupancy !== '0) begin
            n_bad++;
            $display("FAIL mid_reset: got req %b err %b occ %h expected 0 0 0",
                     request, err_grant, occupancy);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_full();
        test_back_to_back();
        test_err_grant();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
